// File: rtl/clock_mode_ctrl_if.sv
// Button/tick inputs and command/display outputs of the MM:SS clock front-end.
// master drives buttons and tick; slave is the controller.
interface clock_mode_ctrl_if;
    logic       tick_1hz;
    logic       btn_pause;
    logic       btn_adj;
    logic       btn_inc;
    logic       btn_dec;
    logic       sec_sel;
    logic       min_sel;
    logic       is_dec;
    logic       blink_sec;
    logic       blink_min;
    logic [1:0] mode;

    modport master (
        output tick_1hz, btn_pause, btn_adj, btn_inc, btn_dec,
        input  sec_sel, min_sel, is_dec, blink_sec, blink_min, mode
    );

    modport slave (
        input  tick_1hz, btn_pause, btn_adj, btn_inc, btn_dec,
        output sec_sel, min_sel, is_dec, blink_sec, blink_min, mode
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Run/pause/set-time controller for the MM:SS counter: turns tick and buttons
// into one-cycle counter strobes, with auto-repeat, blink and idle timeout.
module clock_mode_ctrl #(
    parameter int HOLD_CYC  = 50000000,
    parameter int REP_CYC   = 10000000,
    parameter int BLINK_CYC = 25000000,
    parameter int IDLE_CYC  = 500000000
) (
    input  logic               clk,
    input  logic               reset,
    clock_mode_ctrl_if.slave   bus
);
    localparam int REP_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int RW = $clog2(REP_MAX) + 1;
    localparam int BW = $clog2(BLINK_CYC) + 1;
    localparam int IW = $clog2(IDLE_CYC) + 1;

    localparam logic [RW-1:0] HOLD_W     = RW'(HOLD_CYC);
    localparam logic [RW-1:0] REP_W      = RW'(REP_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYC - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSE   = 2'd1,
        ADJ_SEC = 2'd2,
        ADJ_MIN = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    btn, btn_q, press;
    logic [RW-1:0] rep_cnt, rep_cnt_nxt;
    logic          rep_rpt, rep_rpt_nxt;
    logic          rep_dir, rep_dir_nxt;
    logic [IW-1:0] idle_cnt, idle_cnt_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          sec_q, min_q, dec_q, bsec_q, bmin_q;
    logic          sec_nxt, min_nxt, dec_nxt, bsec_nxt, bmin_nxt;
    logic          fire, fire_dec;

    // bit order: pause, adj, inc, dec
    assign btn   = {bus.btn_pause, bus.btn_adj, bus.btn_inc, bus.btn_dec};
    assign press = btn & ~btn_q;

    always_comb begin
        state_nxt    = state;
        sec_nxt      = 1'b0;
        min_nxt      = 1'b0;
        dec_nxt      = 1'b0;
        rep_cnt_nxt  = '0;
        rep_rpt_nxt  = 1'b0;
        rep_dir_nxt  = rep_dir;
        idle_cnt_nxt = '0;
        fire         = 1'b0;
        fire_dec     = 1'b0;

        case (state)
            RUN: begin
                if (press[2])      state_nxt = ADJ_SEC;
                else if (press[3]) state_nxt = PAUSE;
                if (bus.tick_1hz) begin
                    sec_nxt = 1'b1;
                    min_nxt = 1'b1;
                end
            end
            PAUSE: begin
                if (press[2])      state_nxt = ADJ_SEC;
                else if (press[3]) state_nxt = RUN;
            end
            default: begin
                if (press[2]) begin
                    state_nxt = (state == ADJ_SEC) ? ADJ_MIN : PAUSE;
                end else if (press[3]) begin
                    state_nxt = RUN;
                end else begin
                    // timeout only when nothing is held, so it never collides with a strobe
                    if (|btn)                       idle_cnt_nxt = '0;
                    else if (idle_cnt == IDLE_LAST) state_nxt    = PAUSE;
                    else                            idle_cnt_nxt = idle_cnt + 1'b1;

                    if (bus.btn_inc && bus.btn_dec) begin
                        rep_cnt_nxt = '0;
                    end else if (press[1] || press[0]) begin
                        fire        = 1'b1;
                        fire_dec    = press[0];
                        rep_cnt_nxt = RW'(1);
                        rep_dir_nxt = press[0];
                    end else if (rep_cnt != '0 && (rep_dir ? bus.btn_dec : bus.btn_inc)) begin
                        // first interval is HOLD_CYC, later ones REP_CYC
                        if (rep_cnt == (rep_rpt ? REP_W : HOLD_W)) begin
                            fire        = 1'b1;
                            fire_dec    = rep_dir;
                            rep_cnt_nxt = RW'(1);
                            rep_rpt_nxt = 1'b1;
                        end else begin
                            rep_cnt_nxt = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
                            rep_rpt_nxt = rep_rpt;
                        end
                    end

                    if (fire) begin
                        sec_nxt = (state == ADJ_SEC);
                        min_nxt = (state == ADJ_MIN);
                        dec_nxt = fire_dec;
                    end
                end
            end
        endcase

        blink_cnt_nxt = '0;
        bsec_nxt      = 1'b1;
        bmin_nxt      = 1'b1;
        if (state_nxt == state && state[1]) begin
            bsec_nxt = bsec_q;
            bmin_nxt = bmin_q;
            if (blink_cnt == BLINK_LAST) begin
                if (state == ADJ_SEC) bsec_nxt = ~bsec_q;
                else                  bmin_nxt = ~bmin_q;
            end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PAUSE;
            btn_q     <= btn;
            rep_cnt   <= '0;
            rep_rpt   <= 1'b0;
            rep_dir   <= 1'b0;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            sec_q     <= 1'b0;
            min_q     <= 1'b0;
            dec_q     <= 1'b0;
            bsec_q    <= 1'b1;
            bmin_q    <= 1'b1;
        end else begin
            state     <= state_nxt;
            btn_q     <= btn;
            rep_cnt   <= rep_cnt_nxt;
            rep_rpt   <= rep_rpt_nxt;
            rep_dir   <= rep_dir_nxt;
            idle_cnt  <= idle_cnt_nxt;
            blink_cnt <= blink_cnt_nxt;
            sec_q     <= sec_nxt;
            min_q     <= min_nxt;
            dec_q     <= dec_nxt;
            bsec_q    <= bsec_nxt;
            bmin_q    <= bmin_nxt;
        end
    end

    assign bus.sec_sel   = sec_q;
    assign bus.min_sel   = min_q;
    assign bus.is_dec    = dec_q;
    assign bus.blink_sec = bsec_q;
    assign bus.blink_min = bmin_q;
    assign bus.mode      = state;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed vector bench for clock_mode_ctrl with short test timing parameters.
module tb_clock_mode_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    clock_mode_ctrl_if bus();

    clock_mode_ctrl #(
        .HOLD_CYC(4), .REP_CYC(2), .BLINK_CYC(3), .IDLE_CYC(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // inputs {reset, tick, pause, adj, inc, dec}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_RST  = 6'b100000;
    localparam logic [5:0] I_TICK = 6'b010000;
    localparam logic [5:0] I_PAU  = 6'b001000;
    localparam logic [5:0] I_ADJ  = 6'b000100;
    localparam logic [5:0] I_INC  = 6'b000010;
    localparam logic [5:0] I_DEC  = 6'b000001;

    // expected {sec_sel, min_sel, is_dec, blink_sec, blink_min, mode[1:0]}
    typedef struct {
        logic [5:0] in;
        logic [6:0] exp;
        string      tag;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic [5:0] i, input logic [6:0] e, input string t);
        vec_t v;
        v.in  = i;
        v.exp = e;
        v.tag = t;
        tbl.push_back(v);
    endfunction

    function automatic logic blink_on(input int k);
        return ((k / 3) % 2) == 0;
    endfunction

    function automatic logic [6:0] outs();
        return {bus.sec_sel, bus.min_sel, bus.is_dec, bus.blink_sec, bus.blink_min, bus.mode};
    endfunction

    task automatic apply(input logic [5:0] i);
        reset         = i[5];
        bus.tick_1hz  = i[4];
        bus.btn_pause = i[3];
        bus.btn_adj   = i[2];
        bus.btn_inc   = i[1];
        bus.btn_dec   = i[0];
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        logic       s;
        logic [6:0] got;
        int         strobes, dbl, wrong;
        logic       prev_s;

        bus.tick_1hz  = 1'b0;
        bus.btn_pause = 1'b0;
        bus.btn_adj   = 1'b0;
        bus.btn_inc   = 1'b0;
        bus.btn_dec   = 1'b0;

        // power-on
        add(I_RST,  7'b000_11_01, "reset0");
        add(I_RST,  7'b000_11_01, "reset1");
        add(I_TICK, 7'b000_11_01, "pause_tick");
        add(I_NONE, 7'b000_11_01, "pause_idle");
        // run ticks
        add(I_PAU,  7'b000_11_00, "to_run");
        add(I_NONE, 7'b000_11_00, "run_rel");
        for (int n = 0; n < 3; n++) begin
            add(I_TICK, 7'b110_11_00, "run_tick");
            add(I_NONE, 7'b000_11_00, "run_gap");
        end
        add(I_INC,  7'b000_11_00, "run_inc_ignored");
        add(I_NONE, 7'b000_11_00, "run_inc_rel");
        // ADJ_SEC with dec auto-repeat: strobes at press, +4, +6, +8
        add(I_ADJ, 7'b000_11_10, "to_adj_sec");
        for (int k = 1; k <= 9; k++) begin
            s = (k == 1 || k == 5 || k == 7 || k == 9);
            add(I_DEC, {s, 1'b0, s, blink_on(k), 1'b1, 2'b10}, "dec_hold");
        end
        add(I_NONE, {3'b000, blink_on(10), 1'b1, 2'b10}, "dec_release");
        add(I_PAU,  7'b000_11_00, "adj_to_run");
        add(I_NONE, 7'b000_11_00, "run_again");
        // mode walk
        add(I_ADJ,  7'b000_11_10, "walk_sec");
        add(I_NONE, 7'b000_11_10, "walk_sec_rel");
        add(I_ADJ,  7'b000_11_11, "walk_min");
        add(I_NONE, 7'b000_11_11, "walk_min_rel");
        add(I_INC,  7'b010_11_11, "min_inc");
        add(I_NONE, 7'b000_10_11, "min_blink");
        add(I_ADJ,  7'b000_11_01, "walk_pause");
        add(I_NONE, 7'b000_11_01, "walk_pause_rel");
        // conflicts in ADJ_MIN
        add(I_ADJ,         7'b000_11_10, "c_sec");
        add(I_NONE,        7'b000_11_10, "c_sec_rel");
        add(I_ADJ,         7'b000_11_11, "c_min");
        add(I_NONE,        7'b000_11_11, "c_min_rel");
        add(I_INC | I_DEC, 7'b000_11_11, "both_rise");
        add(I_INC | I_DEC, 7'b000_10_11, "both_held");
        add(I_INC | I_DEC, 7'b000_10_11, "both_held2");
        add(I_INC,         7'b000_10_11, "dec_drop");
        add(I_INC,         7'b000_11_11, "inc_left_held");
        add(I_NONE,        7'b000_11_11, "c_idle");
        add(I_ADJ | I_INC, 7'b000_11_01, "adj_inc_same");
        add(I_NONE,        7'b000_11_01, "adj_inc_rel");
        // idle timeout with blink
        add(I_ADJ, 7'b000_11_10, "to_idle");
        for (int k = 1; k <= 19; k++)
            add(I_NONE, {3'b000, blink_on(k), 1'b1, 2'b10}, "idle_blink");
        add(I_NONE, 7'b000_11_01, "timeout");
        add(I_NONE, 7'b000_11_01, "after_timeout");
        // reset during strobe and hold
        add(I_ADJ,         7'b000_11_10, "r_adj");
        add(I_NONE,        7'b000_11_10, "r_adj_rel");
        add(I_DEC,         7'b101_11_10, "r_dec_press");
        add(I_DEC | I_RST, 7'b000_11_01, "rst_on_strobe");
        add(I_DEC | I_RST, 7'b000_11_01, "rst_hold");
        for (int n = 0; n < 6; n++)
            add(I_DEC, 7'b000_11_01, "post_rst_hold");
        add(I_NONE, 7'b000_11_01, "post_rst_rel");

        foreach (tbl[r]) begin
            apply(tbl[r].in);
            got = outs();
            total++;
            if (got !== tbl[r].exp) begin
                bad++;
                $display("FAIL row %0d %s: got %b want %b", r, tbl[r].tag, got, tbl[r].exp);
            end
        end

        // long inc hold in ADJ_SEC: repeats at +0,+4,+6..+24 and no idle exit
        apply(I_ADJ);
        apply(I_NONE);
        strobes = 0;
        dbl     = 0;
        wrong   = 0;
        prev_s  = 1'b0;
        for (int k = 0; k < 25; k++) begin
            apply(I_INC);
            if (bus.sec_sel === 1'b1) strobes++;
            if (bus.sec_sel === 1'b1 && prev_s) dbl++;
            if (bus.min_sel !== 1'b0 || bus.is_dec !== 1'b0) wrong++;
            prev_s = bus.sec_sel;
        end
        check("hold_strobe_count", strobes, 12);
        check("hold_strobe_width", dbl, 0);
        check("hold_wrong_field", wrong, 0);
        check("hold_mode", int'(bus.mode), 2);
        strobes = 0;
        for (int k = 0; k < 3; k++) begin
            apply(I_NONE);
            if (bus.sec_sel === 1'b1) strobes++;
        end
        check("release_no_strobe", strobes, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Front-end controller for the MM:SS clock counter. It turns a 1 Hz tick and debounced user buttons into the counter's one-cycle command strobes: sec_sel, min_sel and is_dec. It implements run, pause and two set-time modes. In the set-time modes it adds press-and-hold auto-repeat, a blink enable for the display and an inactivity timeout.

Parameters:
HOLD_CYC, 50000000, cycles inc/dec must stay held after the press before auto-repeat starts (>=2)
REP_CYC, 10000000, cycles between auto-repeat strobes while held (>=1)
BLINK_CYC, 25000000, half-period of blink in cycles (>=1)
IDLE_CYC, 500000000, cycles without any button activity in an adjust mode before automatic exit (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick_1hz  input  1  one-cycle pulse, once per second
btn_pause  input  1  debounced level, run/pause toggle
btn_adj  input  1  debounced level, mode advance
btn_inc  input  1  debounced level, increment selected field
btn_dec  input  1  debounced level, decrement selected field
sec_sel  output  1  command strobe to counter (seconds)
min_sel  output  1  command strobe to counter (minutes / carry enable)
is_dec  output  1  direction qualifier, valid while any strobe is high
blink_sec  output  1  1 = seconds digits visible; toggles in ADJ_SEC, else 1
blink_min  output  1  1 = minutes digits visible; toggles in ADJ_MIN, else 1
mode  output  2  current state encoding: 0 RUN, 1 PAUSE, 2 ADJ_SEC, 3 ADJ_MIN

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high. Reset has priority over all other inputs.
- Reset values: state=PAUSE, sec_sel=min_sel=is_dec=0, blink_sec=blink_min=1, all counters=0. Button history registers are loaded from the current button levels, so a button already held at reset release produces no press.
- Press: a btn_* input is 1 at edge N and was 0 at edge N-1. Press detection is internal.
- Strobe timing: all outputs are registered. A strobe caused by an event sampled at edge N is high for exactly the one cycle after edge N. Strobes never last longer than one cycle.
- RUN:
  - tick_1hz produces sec_sel=1, min_sel=1, is_dec=0. This is the counter's cascaded count-up mode.
  - btn_pause press -> PAUSE. btn_adj press -> ADJ_SEC.
  - btn_inc and btn_dec are ignored.
- PAUSE:
  - tick_1hz is ignored; no strobes are issued.
  - btn_pause press -> RUN. btn_adj press -> ADJ_SEC.
- ADJ_SEC / ADJ_MIN:
  - tick_1hz is ignored.
  - btn_inc press: ADJ_SEC gives sec_sel=1, min_sel=0, is_dec=0. ADJ_MIN gives sec_sel=0, min_sel=1, is_dec=0.
  - btn_dec press: same strobe as btn_inc, with is_dec=1.
- Auto-repeat:
  - A repeat counter starts on the press.
  - If the same button is still held HOLD_CYC cycles after the press, a repeat strobe fires.
  - Further repeat strobes fire every REP_CYC cycles after that while the button stays held.
  - Releasing the button clears the counter.
- Simultaneous inc and dec: inc and dec both held, or both pressed at the same edge, issue no strobe and clear the repeat counter.
- Mode advance: btn_adj press moves ADJ_SEC -> ADJ_MIN and ADJ_MIN -> PAUSE. btn_pause press in either adjust mode -> RUN.
- Button priority at the same edge: btn_adj beats btn_pause, which beats inc/dec. A mode change at an edge suppresses any inc/dec strobe at that edge and clears the repeat counter.
- Idle timeout:
  - The idle counter clears on any press or held button.
  - It increments each cycle spent in ADJ_SEC or ADJ_MIN.
  - At IDLE_CYC the state -> PAUSE, with no strobe issued.
- Blink:
  - The blink counter runs only in adjust modes and toggles the active field's blink output every BLINK_CYC cycles.
  - On entry to any state, the counter resets and both blink outputs are 1.
- Width: counters are sized with $clog2 of their parameter plus 1. Counters saturate; they never wrap.
- Reset during an active strobe or hold: outputs return to reset values at the next edge, and no residual strobe is issued.

Test Plan:
- Test parameters: HOLD_CYC=4, REP_CYC=2, BLINK_CYC=3, IDLE_CYC=20. All tests start after reset.
- Power-on: reset 2 cycles -> mode=0b01 (PAUSE), strobes 0, blink outputs 1. A tick_1hz pulse produces no strobe.
- Run tick: btn_pause press then 3 tick_1hz pulses -> mode=00. Each tick gives exactly one cycle of sec_sel=1, min_sel=1, is_dec=0, one cycle after the tick edge.
- Adjust with repeat: btn_adj press (mode=10), then btn_dec held 9 cycles -> sec_sel strobes with is_dec=1 one cycle after the press edge, then after press+4, press+6 and press+8. Total 4 strobes; min_sel stays 0.
- Mode walk: btn_adj press twice from RUN -> 10 then 11. btn_inc press in 11 gives min_sel=1, sec_sel=0. A third btn_adj press -> 01.
- Conflicts: in ADJ_MIN, btn_inc and btn_dec rise together -> no strobe. btn_adj and btn_inc pressed at the same edge -> mode=01 and no strobe.
- Timeout and blink: enter ADJ_SEC and idle -> blink_sec toggles every 3 cycles and blink_min stays 1. At 20 idle cycles mode=01 and blink_sec=1. Reset asserted mid-hold -> no strobe after reset.
